// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants, state encoding and command record for the VRAM cycle engine
package vram_pkg;

  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  localparam int DEFAULT_DURATION_WIDTH = 6;
  localparam int MAX_DURATION           = (1 << DEFAULT_DURATION_WIDTH) - 1;

  // One-hot state encoding; TURN only reachable with VRAM_CYCLE_TURNAROUND_EN
  localparam logic [6:0] ST_IDLE        = 7'b000_0001;
  localparam logic [6:0] ST_SETUP       = 7'b000_0010;
  localparam logic [6:0] ST_WRITE_PULSE = 7'b000_0100;
  localparam logic [6:0] ST_WRITE_HOLD  = 7'b000_1000;
  localparam logic [6:0] ST_READ_STROBE = 7'b001_0000;
  localparam logic [6:0] ST_READ_RESP   = 7'b010_0000;
  localparam logic [6:0] ST_TURN        = 7'b100_0000;

  typedef struct packed {
    logic        write;
    logic        va14;
    logic [13:0] vaa;
    logic [13:0] vab;
    logic [7:0]  vda;
    logic [7:0]  vdb;
  } vram_cmd_t;

endpackage

// File: rtl/vram_cycle_timer.sv
// rtl/vram_cycle_timer.sv - loadable down-counter, done when the count reaches zero
module vram_cycle_timer
  #(parameter int WIDTH = 6)
  (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
  );

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/vram_cycle_engine.sv
// rtl/vram_cycle_engine.sv - SNES VRAM bus-cycle sequencer; VRAM_CYCLE_TURNAROUND_EN adds a TURN state after writes
module vram_cycle_engine
  import vram_pkg::*;
  #(parameter int DURATION_WIDTH = DEFAULT_DURATION_WIDTH)
  (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic                      cmd_va14_i,
  input  logic [13:0]               cmd_vaa_i,
  input  logic [13:0]               cmd_vab_i,
  input  logic [7:0]                cmd_vda_i,
  input  logic [7:0]                cmd_vdb_i,
  input  logic [DURATION_WIDTH-1:0] write_duration_i,
  input  logic [DURATION_WIDTH-1:0] read_delay_i,
  output logic                      rsp_valid_o,
  output logic [7:0]                rsp_vda_o,
  output logic [7:0]                rsp_vdb_o,
  output logic                      vrd_n,
  output logic                      vawr_n,
  output logic                      vbwr_n,
  output logic                      va14,
  output logic [13:0]               vaa,
  output logic [13:0]               vab,
  output logic                      vd_dir,
  output logic [7:0]                vda_o,
  output logic [7:0]                vdb_o,
  input  logic [7:0]                vda_i,
  input  logic [7:0]                vdb_i
  );

  logic [6:0] state;
  logic [6:0] next_state;
  vram_cmd_t  cmd_q;
  logic       handshake;
  logic       timer_done;
  logic       timer_dec;
  logic       in_write_pulse;
  logic       in_read_strobe;

  assign handshake      = cmd_valid_i && cmd_ready_o;
  assign in_write_pulse = (state == ST_WRITE_PULSE);
  assign in_read_strobe = (state == ST_READ_STROBE);
  assign timer_dec      = in_write_pulse || in_read_strobe;

  // Only the duration relevant to the accepted command is captured; it lives in the timer
  vram_cycle_timer #(.WIDTH(DURATION_WIDTH)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (handshake),
    .load_value (cmd_write_i ? write_duration_i : read_delay_i),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE:        next_state = cmd_valid_i ? ST_SETUP : ST_IDLE;
      ST_SETUP:       next_state = cmd_q.write ? ST_WRITE_PULSE : ST_READ_STROBE;
      ST_WRITE_PULSE: next_state = timer_done ? ST_WRITE_HOLD : ST_WRITE_PULSE;
`ifdef VRAM_CYCLE_TURNAROUND_EN
      ST_WRITE_HOLD:  next_state = ST_TURN;
      ST_TURN:        next_state = ST_IDLE;
`else
      ST_WRITE_HOLD:  next_state = ST_IDLE;
`endif
      ST_READ_STROBE: next_state = timer_done ? ST_READ_RESP : ST_READ_STROBE;
      ST_READ_RESP:   next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q <= '0;
    end else if (handshake) begin
      cmd_q <= '{write: cmd_write_i, va14: cmd_va14_i, vaa: cmd_vaa_i,
                 vab: cmd_vab_i, vda: cmd_vda_i, vdb: cmd_vdb_i};
    end
  end

  // Pins are sampled on the edge that closes the final strobe cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_vda_o <= '0;
      rsp_vdb_o <= '0;
    end else if (in_read_strobe && timer_done) begin
      rsp_vda_o <= vda_i;
      rsp_vdb_o <= vdb_i;
    end
  end

  // Full-state compares keep illegal encodings from asserting any strobe
  assign cmd_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_READ_RESP);
  assign vrd_n       = !in_read_strobe;
  assign vawr_n      = !in_write_pulse;
  assign vbwr_n      = !in_write_pulse;

  assign va14  = cmd_q.va14;
  assign vaa   = cmd_q.vaa;
  assign vab   = cmd_q.vab;
  assign vda_o = cmd_q.vda;
  assign vdb_o = cmd_q.vdb;

  assign vd_dir = (cmd_q.write && ((state == ST_SETUP) || in_write_pulse ||
                                   (state == ST_WRITE_HOLD)))
                  ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;

endmodule

// File: tb/tb_vram_cycle_engine.sv
// tb/tb_vram_cycle_engine.sv - directed table-driven bench for vram_cycle_engine
module tb_vram_cycle_engine;
  import vram_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic        cmd_va14_i;
  logic [13:0] cmd_vaa_i;
  logic [13:0] cmd_vab_i;
  logic [7:0]  cmd_vda_i;
  logic [7:0]  cmd_vdb_i;
  logic [5:0]  write_duration_i;
  logic [5:0]  read_delay_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_vda_o;
  logic [7:0]  rsp_vdb_o;
  logic        vrd_n;
  logic        vawr_n;
  logic        vbwr_n;
  logic        va14;
  logic [13:0] vaa;
  logic [13:0] vab;
  logic        vd_dir;
  logic [7:0]  vda_o;
  logic [7:0]  vdb_o;
  logic [7:0]  vda_i;
  logic [7:0]  vdb_i;

  int tests_run;
  int tests_failed;

`ifdef VRAM_CYCLE_TURNAROUND_EN
  localparam int TURN_EXTRA = 1;
`else
  localparam int TURN_EXTRA = 0;
`endif

  vram_cycle_engine #(.DURATION_WIDTH(6)) dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_write_i      (cmd_write_i),
    .cmd_va14_i       (cmd_va14_i),
    .cmd_vaa_i        (cmd_vaa_i),
    .cmd_vab_i        (cmd_vab_i),
    .cmd_vda_i        (cmd_vda_i),
    .cmd_vdb_i        (cmd_vdb_i),
    .write_duration_i (write_duration_i),
    .read_delay_i     (read_delay_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_vda_o        (rsp_vda_o),
    .rsp_vdb_o        (rsp_vdb_o),
    .vrd_n            (vrd_n),
    .vawr_n           (vawr_n),
    .vbwr_n           (vbwr_n),
    .va14             (va14),
    .vaa              (vaa),
    .vab              (vab),
    .vd_dir           (vd_dir),
    .vda_o            (vda_o),
    .vdb_o            (vdb_o),
    .vda_i            (vda_i),
    .vdb_i            (vdb_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        a14;
    logic [13:0] addr_a;
    logic [13:0] addr_b;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic [5:0]  dur;
    logic [7:0]  pin_a;
    logic [7:0]  pin_b;
    int          s_first;
    int          s_last;
    int          dir_cnt;
    int          rsp_cyc;
    int          ready_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic set_cmd(input logic wr, input logic a14, input logic [13:0] a, input logic [13:0] b,
                         input logic [7:0] da, input logic [7:0] db, input logic [5:0] d);
    cmd_write_i      = wr;
    cmd_va14_i       = a14;
    cmd_vaa_i        = a;
    cmd_vab_i        = b;
    cmd_vda_i        = da;
    cmd_vdb_i        = db;
    write_duration_i = wr ? d : ~d;
    read_delay_i     = wr ? ~d : d;
  endtask

  task automatic scramble_inputs();
    cmd_write_i      = ~cmd_write_i;
    cmd_va14_i       = ~cmd_va14_i;
    cmd_vaa_i        = ~cmd_vaa_i;
    cmd_vab_i        = ~cmd_vab_i;
    cmd_vda_i        = ~cmd_vda_i;
    cmd_vdb_i        = ~cmd_vdb_i;
    write_duration_i = ~write_duration_i;
    read_delay_i     = ~read_delay_i;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int first, last, cnt, other_cnt, split, dir_cnt, data_bad, addr_bad;
    int rsp_at, rsp_cnt, ready_at;
    logic [7:0] ra, rb;
    logic main_low, other_low;
    v = vecs[idx];
    first = -1; last = -1; cnt = 0; other_cnt = 0; split = 0; dir_cnt = 0;
    data_bad = 0; addr_bad = 0; rsp_at = -1; rsp_cnt = 0; ready_at = -1;
    ra = 8'h00; rb = 8'h00;
    @(negedge clock);
    set_cmd(v.wr, v.a14, v.addr_a, v.addr_b, v.data_a, v.data_b, v.dur);
    vda_i = v.pin_a;
    vdb_i = v.pin_b;
    cmd_valid_i = 1'b1;
    check($sformatf("v%0d ready_c0", idx), {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clock);
    #1;
    cmd_valid_i = 1'b0;
    scramble_inputs();
    for (int c = 1; c <= 150; c++) begin
      @(negedge clock);
      main_low  = v.wr ? (!vawr_n || !vbwr_n) : !vrd_n;
      other_low = v.wr ? !vrd_n : (!vawr_n || !vbwr_n);
      if (main_low) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (other_low) other_cnt++;
      if (vawr_n !== vbwr_n) split++;
      if (vd_dir === LVL_DIR_OUTPUT) begin
        dir_cnt++;
        if (vda_o !== v.data_a || vdb_o !== v.data_b) data_bad++;
      end
      if (va14 !== v.a14 || vaa !== v.addr_a || vab !== v.addr_b) addr_bad++;
      if (rsp_valid_o) begin
        rsp_cnt++;
        rsp_at = c;
        ra = rsp_vda_o;
        rb = rsp_vdb_o;
      end
      if (cmd_ready_o) begin
        ready_at = c;
        break;
      end
    end
    check($sformatf("v%0d strobe_first", idx), first, v.s_first);
    check($sformatf("v%0d strobe_last", idx), last, v.s_last);
    check($sformatf("v%0d strobe_width", idx), cnt, v.s_last - v.s_first + 1);
    check($sformatf("v%0d other_strobe", idx), other_cnt, 0);
    check($sformatf("v%0d wr_split", idx), split, 0);
    check($sformatf("v%0d dir_cycles", idx), dir_cnt, v.dir_cnt);
    check($sformatf("v%0d data_out", idx), data_bad, 0);
    check($sformatf("v%0d addr_held", idx), addr_bad, 0);
    check($sformatf("v%0d ready_cycle", idx), ready_at, v.ready_cyc);
    check($sformatf("v%0d rsp_count", idx), rsp_cnt, v.wr ? 0 : 1);
    if (!v.wr) begin
      check($sformatf("v%0d rsp_cycle", idx), rsp_at, v.rsp_cyc);
      check($sformatf("v%0d rsp_data", idx), {16'd0, ra, rb}, {16'd0, v.pin_a, v.pin_b});
      check($sformatf("v%0d rsp_held", idx), {16'd0, rsp_vda_o, rsp_vdb_o}, {16'd0, v.pin_a, v.pin_b});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, {31'd0, cmd_ready_o}, 32'd1);
    check({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    check({tag, " strobes"}, {29'd0, vrd_n, vawr_n, vbwr_n}, 32'd7);
    check({tag, " vd_dir"}, {31'd0, vd_dir}, {31'd0, LVL_DIR_INPUT});
  endtask

  initial begin
    int ready1, vrd_first, rsp_at, wr_first, rsp_cnt;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    cmd_valid_i = 1'b0;
    set_cmd(1'b0, 1'b0, 14'h0, 14'h0, 8'h0, 8'h0, 6'd0);
    vda_i = 8'h00;
    vdb_i = 8'h00;

    //          wr    a14   vaa       vab       vda    vdb    D      pa     pb     first last dir rsp ready
    vecs[0] = '{1'b1, 1'b1, 14'h1234, 14'h0ABC, 8'h5A, 8'hA5, 6'd0,  8'h00, 8'h00, 2, 2,  3,  0,  4 + TURN_EXTRA};
    vecs[1] = '{1'b0, 1'b0, 14'h2001, 14'h1FFE, 8'h00, 8'h00, 6'd3,  8'hC3, 8'h3C, 2, 5,  0,  6,  7};
    vecs[2] = '{1'b0, 1'b1, 14'h3FFF, 14'h0001, 8'h11, 8'h22, 6'd63, 8'h81, 8'h7E, 2, 65, 0,  66, 67};
    vecs[3] = '{1'b1, 1'b0, 14'h0555, 14'h2AAA, 8'hF0, 8'h0F, 6'd63, 8'h00, 8'h00, 2, 65, 66, 0,  67 + TURN_EXTRA};
    vecs[4] = '{1'b1, 1'b0, 14'h0100, 14'h0200, 8'h96, 8'h69, 6'd5,  8'h00, 8'h00, 2, 7,  8,  0,  9 + TURN_EXTRA};

    repeat (2) @(negedge clock);
    check_idle_outputs("reset_asserted");
    check("reset rsp_data", {16'd0, rsp_vda_o, rsp_vdb_o}, 32'd0);
    check("reset addr", {3'd0, va14, vaa, vab}, 32'd0);
    check("reset data_out", {16'd0, vda_o, vdb_o}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("reset_released");

    for (int i = 0; i < 5; i++) run_vec(i);

    // Write D=1 then read D=2 with valid held high across both commands
    @(negedge clock);
    set_cmd(1'b1, 1'b0, 14'h0AAA, 14'h1555, 8'h12, 8'h34, 6'd1);
    vda_i = 8'hE7;
    vdb_i = 8'h18;
    cmd_valid_i = 1'b1;
    @(posedge clock);
    #1;
    set_cmd(1'b0, 1'b1, 14'h0F0F, 14'h30F0, 8'h00, 8'h00, 6'd2);
    ready1 = -1; vrd_first = -1; rsp_at = -1; wr_first = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (!vawr_n && wr_first < 0) wr_first = c;
      if (!vrd_n && vrd_first < 0) vrd_first = c;
      if (rsp_valid_o && rsp_at < 0) rsp_at = c;
      if (cmd_ready_o && ready1 < 0) begin
        ready1 = c;
        @(posedge clock);
        #1;
        cmd_valid_i = 1'b0;
      end
    end
    check("b2b wr_first", wr_first, 2);
    check("b2b first_idle", ready1, 5 + TURN_EXTRA);
    check("b2b vrd_first", vrd_first, 7 + TURN_EXTRA);
    check("b2b rsp_cycle", rsp_at, 10 + TURN_EXTRA);
    check("b2b rsp_data", {16'd0, rsp_vda_o, rsp_vdb_o}, 32'h0000E718);
    check("b2b read_addr", {3'd0, va14, vaa, vab}, {3'd0, 1'b1, 14'h0F0F, 14'h30F0});

    // Reset asserted in the middle of a long write pulse
    @(negedge clock);
    set_cmd(1'b1, 1'b1, 14'h1111, 14'h2222, 8'h33, 8'h44, 6'd10);
    cmd_valid_i = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_wr in_pulse", {30'd0, vawr_n, vbwr_n}, 32'd0);
    check("abort_wr dir_out", {31'd0, vd_dir}, {31'd0, LVL_DIR_OUTPUT});
    #2;
    reset = 1'b0;
    #1;
    check("abort_wr strobes", {29'd0, vrd_n, vawr_n, vbwr_n}, 32'd7);
    check("abort_wr vd_dir", {31'd0, vd_dir}, {31'd0, LVL_DIR_INPUT});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("abort_wr released");
    check("abort_wr addr_cleared", {3'd0, va14, vaa, vab}, 32'd0);

    // Reset in the middle of a read strobe must not yield a response
    @(negedge clock);
    set_cmd(1'b0, 1'b0, 14'h0123, 14'h0321, 8'h00, 8'h00, 6'd10);
    vda_i = 8'h5C;
    vdb_i = 8'hC5;
    cmd_valid_i = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_rd in_strobe", {31'd0, vrd_n}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rd vrd_n", {31'd0, vrd_n}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (rsp_valid_o) rsp_cnt++;
    end
    check("abort_rd no_rsp", rsp_cnt, 0);
    check("abort_rd rsp_data", {16'd0, rsp_vda_o, rsp_vdb_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vram_cycle_engine.md
# vram_cycle_engine

Bus-cycle sequencer that sits directly downstream of the VRAM command decoder in the VRAM bringup design. It accepts one read or write command at a time, holding address, data and timing values. It drives the SNES VRAM strobes, address buses and data direction with programmable pulse widths. It returns the sampled read data to the decoder for transmission over the UART.

## Interface
- DURATION_WIDTH, 6, width of write-duration and read-delay fields
- clock  in  1  system clock
- reset  in  1  one clock; reset is asynchronous and active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  engine can accept a command
- cmd_write_i  in  1  1 = write cycle, 0 = read cycle
- cmd_va14_i  in  1  VA14 value for the cycle
- cmd_vaa_i / cmd_vab_i  in  14 each  chip A/B address
- cmd_vda_i / cmd_vdb_i  in  8 each  chip A/B write data
- write_duration_i  in  DURATION_WIDTH  write strobe width minus one
- read_delay_i  in  DURATION_WIDTH  read strobe width minus one
- rsp_valid_o  out  1  one-cycle pulse, read data valid
- rsp_vda_o / rsp_vdb_o  out  8 each  sampled read data, held until next sample
- vrd_n, vawr_n, vbwr_n  out  1 each  VRAM strobes, active-low
- va14  out  1; vaa / vab  out  14 each  VRAM address
- vd_dir  out  1  data-pin direction, LVL_DIR_OUTPUT while writing, else LVL_DIR_INPUT
- vda_o / vdb_o  out  8 each  data to pin_bidir_8; vda_i / vdb_i  in  8 each  data from pins

## Operation
- States: IDLE, SETUP, WRITE_PULSE, WRITE_HOLD, READ_STROBE, READ_RESP, plus TURN when configured.
- cmd_ready_o = (state == IDLE). Handshake occurs on a clock edge with cmd_valid_i && cmd_ready_o.
- At handshake, all cmd_* fields and both duration inputs are latched. Later input changes have no effect until the next handshake.
- IDLE -> SETUP on handshake. The address is driven from SETUP onward and held until the next command. For writes, vd_dir = OUTPUT and vda_o/vdb_o are driven in SETUP.
- SETUP -> WRITE_PULSE (write) or READ_STROBE (read).
- WRITE_PULSE: vawr_n = vbwr_n = 0 for latched duration + 1 cycles, then WRITE_HOLD.
- WRITE_HOLD: strobes high, data and direction still driven for 1 cycle, then IDLE (or TURN).
- READ_STROBE: vrd_n = 0 for latched delay + 1 cycles. vda_i/vdb_i are registered into rsp_* on the edge that ends the last strobe cycle. Then READ_RESP.
- READ_RESP: vrd_n = 1, rsp_valid_o = 1 for exactly 1 cycle, then IDLE.
- At most one strobe is low at any time. vd_dir = OUTPUT only in SETUP/WRITE_PULSE/WRITE_HOLD of a write.
- Illegal state encoding: force IDLE with strobes deasserted.

## Timing
- Reset values: cmd_ready_o 1, rsp_valid_o 0, rsp_vda_o/rsp_vdb_o 0, vrd_n/vawr_n/vbwr_n 1, va14 0, vaa/vab 0, vd_dir INPUT, vda_o/vdb_o 0.
- Accept cycle = 0, D = latched duration.
- Write: strobes low in cycles 2..D+2, hold in cycle D+3, ready in cycle D+4.
- Read: vrd_n low in cycles 2..D+2, rsp_valid_o in cycle D+3, ready in cycle D+4.
- D = 0 gives a 1-cycle strobe. D = 63 gives a 64-cycle strobe. No wrap or overflow is possible.
- Back-to-back commands: a new handshake is possible in the first IDLE cycle. No command is lost if cmd_valid_i stays high.
- Reset asserted mid-cycle: all strobes go high and vd_dir goes INPUT asynchronously. No rsp_valid_o is issued for the aborted read.

## Configuration
- VRAM_CYCLE_TURNAROUND_EN defined: WRITE_HOLD -> TURN, a 1-cycle state with strobes high, vd_dir INPUT, ready 0, address held. Write ready moves to cycle D+5. Read timing is unchanged.
- Undefined: no TURN state, WRITE_HOLD -> IDLE.

## Structure
- Shared package vram_pkg holds:
  - LVL_DIR_INPUT / LVL_DIR_OUTPUT
  - state encoding localparams (one-hot)
  - default DURATION_WIDTH
  - MAX_DURATION
- Sub-module vram_cycle_timer: loadable down-counter with a done flag, reused for write pulse and read strobe.

## Test plan
- Write, vaa=14'h1234, vab=14'h0ABC, vda=8'h5A, vdb=8'hA5, D=0 -> vawr_n/vbwr_n low exactly cycle 2, vd_dir OUTPUT cycles 1-3, ready in cycle 4.
- Read, D=3, pins vda_i=8'hC3, vdb_i=8'h3C -> vrd_n low cycles 2-5, rsp_valid_o in cycle 6 with rsp=C3/3C, no write strobe.
- D=63 read -> 64-cycle vrd_n pulse, vd_dir never OUTPUT.
- Write immediately followed by read, cmd_valid_i held high -> second handshake in first IDLE cycle. One extra INPUT cycle between them when VRAM_CYCLE_TURNAROUND_EN is defined.
- Reset asserted mid WRITE_PULSE -> strobes 1 and vd_dir INPUT before next edge, cmd_ready_o 1 after release.
- Change cmd_* and durations during a cycle -> strobe width and address unaffected.
